// File: rtl/contract_issue_sequencer.sv
// contract_issue_sequencer
//   Per-hart issue gate for contract-synthesis runs. One instance sits beside
//   NrHarts cores, drives each core's issue enable and watches its issue
//   strobe. A host command puts a hart in RUN, HALT or STEP-N (issue exactly
//   N instructions, then stop). The block also keeps a per-hart issue counter
//   and a sticky flag for issues seen while the gate was closed.
//
//   Optional feature macro: ISSUE_WATCHDOG_EN
//     Defined   -> a per-hart idle counter aborts a STEP that sees no issue
//                  for WdogCycles cycles and raises timeout_o.
//     Undefined -> no idle counter, timeout_o is constant 0, STEP waits forever.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active high
//   cmd_valid_i    host command valid
//   cmd_ready_o    command accepted on a rising edge when valid & ready
//   cmd_hart_i     target hart; out-of-range indices are accepted and ignored
//   cmd_op_i       0=HALT 1=RUN 2=STEP 3=CLEAR
//   cmd_count_i    instruction count for STEP
//   issue_i        per-hart issue strobe from the core (max one per cycle)
//   enable_issue_o per-hart issue enable to the core
//   issue_cnt_o    per-hart issue count, hart h at [h*CntW +: CntW]
//   step_done_o    one-cycle pulse when a STEP completes
//   spurious_o     sticky: issue seen while enable_issue_o was low
//   timeout_o      sticky: watchdog aborted a STEP

module contract_issue_sequencer #(
  parameter int NrHarts    = 2,
  parameter int CntW       = 16,
  parameter int WdogCycles = 1024
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           cmd_valid_i,
  output logic                                           cmd_ready_o,
  input  logic [((NrHarts > 1) ? $clog2(NrHarts) : 1)-1:0] cmd_hart_i,
  input  logic [1:0]                                     cmd_op_i,
  input  logic [CntW-1:0]                                cmd_count_i,
  input  logic [NrHarts-1:0]                             issue_i,
  output logic [NrHarts-1:0]                             enable_issue_o,
  output logic [NrHarts*CntW-1:0]                        issue_cnt_o,
  output logic [NrHarts-1:0]                             step_done_o,
  output logic [NrHarts-1:0]                             spurious_o,
  output logic [NrHarts-1:0]                             timeout_o
);

  localparam int HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;

  localparam logic [1:0] OpHalt  = 2'd0;
  localparam logic [1:0] OpRun   = 2'd1;
  localparam logic [1:0] OpStep  = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_e;

  state_e              state_q [NrHarts];
  logic [CntW-1:0]     rem_q   [NrHarts];
  logic [CntW-1:0]     cnt_q   [NrHarts];
  logic [NrHarts-1:0]  done_q;
  logic [NrHarts-1:0]  spur_q;

  logic [NrHarts-1:0]  cmd_hit;    // accepted command addressed to this hart
  logic [NrHarts-1:0]  clr_hit;    // accepted CLEAR addressed to this hart
  logic [NrHarts-1:0]  wdog_fire;  // watchdog aborts the step on this edge

  // ---------------------------------------------------------------------------
  // Command handshake. Only a STEP aimed at a hart that is still stepping is
  // back-pressured; everything else is taken immediately.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd_ready_o = 1'b1;
    for (int h = 0; h < NrHarts; h++) begin
      if (cmd_op_i == OpStep && cmd_hart_i == HartW'(h) && state_q[h] == STEPPING)
        cmd_ready_o = 1'b0;
    end
  end

  always_comb begin
    cmd_hit = '0;
    clr_hit = '0;
    for (int h = 0; h < NrHarts; h++) begin
      cmd_hit[h] = cmd_valid_i && cmd_ready_o && (cmd_hart_i == HartW'(h));
      clr_hit[h] = cmd_hit[h] && (cmd_op_i == OpClear);
    end
  end

  // Enable is decoded from registered state only, so it never depends
  // combinationally on issue_i or on the command inputs.
  always_comb begin
    enable_issue_o = '0;
    for (int h = 0; h < NrHarts; h++) begin
      unique case (state_q[h])
        RUNNING:  enable_issue_o[h] = 1'b1;
        STEPPING: enable_issue_o[h] = (rem_q[h] != '0);
        default:  enable_issue_o[h] = 1'b0;
      endcase
    end
  end

  always_comb begin
    issue_cnt_o = '0;
    for (int h = 0; h < NrHarts; h++) issue_cnt_o[h*CntW +: CntW] = cnt_q[h];
  end

  assign step_done_o = done_q;
  assign spurious_o  = spur_q;

`ifdef ISSUE_WATCHDOG_EN
  // ---------------------------------------------------------------------------
  // Step watchdog: counts idle cycles while stepping. The counter saturates
  // at WdogCycles-1, which is the value that aborts the step.
  // ---------------------------------------------------------------------------
  localparam int IdleW = (WdogCycles > 2) ? $clog2(WdogCycles) : 1;

  logic [IdleW-1:0]   idle_q [NrHarts];
  logic [NrHarts-1:0] tmo_q;

  always_comb begin
    wdog_fire = '0;
    for (int h = 0; h < NrHarts; h++) begin
      wdog_fire[h] = (state_q[h] == STEPPING) && !issue_i[h] &&
                     (idle_q[h] == IdleW'(WdogCycles - 1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int h = 0; h < NrHarts; h++) idle_q[h] <= '0;
      tmo_q <= '0;
    end else begin
      for (int h = 0; h < NrHarts; h++) begin
        // Restart on any issue, on abort, and whenever the hart is (or is
        // about to be) out of STEPPING. CLEAR does not disturb the step.
        if (state_q[h] != STEPPING || issue_i[h] || wdog_fire[h] ||
            (cmd_hit[h] && !clr_hit[h]))
          idle_q[h] <= '0;
        else
          idle_q[h] <= idle_q[h] + 1'b1;

        if (clr_hit[h])        tmo_q[h] <= 1'b0;
        else if (wdog_fire[h]) tmo_q[h] <= 1'b1;
      end
    end
  end

  assign timeout_o = tmo_q;
`else
  assign wdog_fire = '0;
  assign timeout_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // Per-hart state, remaining count, issue counter and flags.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the order.
  // NOTE: the per-hart arrays are ordinary flops (not RAM), so they are all
  // reset explicitly; a step in flight is simply dropped by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int h = 0; h < NrHarts; h++) begin
        state_q[h] <= HALTED;
        rem_q[h]   <= '0;
        cnt_q[h]   <= '0;
      end
      done_q <= '0;
      spur_q <= '0;
    end else begin
      for (int h = 0; h < NrHarts; h++) begin
        done_q[h] <= 1'b0;

        // Issue counter: an issue in the same cycle as CLEAR leaves 1.
        if (clr_hit[h])      cnt_q[h] <= issue_i[h] ? CntW'(1) : '0;
        else if (issue_i[h]) cnt_q[h] <= cnt_q[h] + 1'b1;

        if (clr_hit[h])                               spur_q[h] <= 1'b0;
        else if (issue_i[h] && !enable_issue_o[h])    spur_q[h] <= 1'b1;

        // A state-changing command overrides both the watchdog and a
        // simultaneous last-step issue (no done pulse in that case).
        if (cmd_hit[h] && !clr_hit[h]) begin
          unique case (cmd_op_i)
            OpHalt: begin
              state_q[h] <= HALTED;
              rem_q[h]   <= '0;
            end
            OpRun: begin
              state_q[h] <= RUNNING;
              rem_q[h]   <= '0;
            end
            OpStep: begin
              if (cmd_count_i == '0) begin
                state_q[h] <= HALTED;
                rem_q[h]   <= '0;
                done_q[h]  <= 1'b1;
              end else begin
                state_q[h] <= STEPPING;
                rem_q[h]   <= cmd_count_i;
              end
            end
            default: ;
          endcase
        end else if (wdog_fire[h]) begin
          state_q[h] <= HALTED;
          rem_q[h]   <= '0;
        end else if (state_q[h] == STEPPING && issue_i[h] && rem_q[h] != '0) begin
          rem_q[h] <= rem_q[h] - 1'b1;
          if (rem_q[h] == CntW'(1)) begin
            state_q[h] <= HALTED;
            done_q[h]  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_contract_issue_sequencer.sv
// tb_contract_issue_sequencer
//   Self-checking bench for contract_issue_sequencer with three harts and a
//   4-bit counter. A simple core model issues every cycle its gate is open
//   (per-hart core_go), and issue_force injects issues regardless of the gate.
//   Every STEP expected to complete pushes its final issue count to a
//   scoreboard that is popped on each step_done_o pulse.

module tb_contract_issue_sequencer;

  localparam int NrHarts    = 3;
  localparam int CntW       = 4;
  localparam int WdogCycles = 8;
  localparam int HartW      = 2;

  localparam logic [1:0] OpHalt  = 2'd0;
  localparam logic [1:0] OpRun   = 2'd1;
  localparam logic [1:0] OpStep  = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [HartW-1:0]        cmd_hart_i;
  logic [1:0]              cmd_op_i;
  logic [CntW-1:0]         cmd_count_i;
  logic [NrHarts-1:0]      issue_i;
  logic [NrHarts-1:0]      enable_issue_o;
  logic [NrHarts*CntW-1:0] issue_cnt_o;
  logic [NrHarts-1:0]      step_done_o;
  logic [NrHarts-1:0]      spurious_o;
  logic [NrHarts-1:0]      timeout_o;

  logic [NrHarts-1:0]      core_go;
  logic [NrHarts-1:0]      issue_force;

  // Core model: issues whenever enabled and willing, plus forced issues.
  assign issue_i = issue_force | (enable_issue_o & core_go);

  contract_issue_sequencer #(
    .NrHarts   (NrHarts),
    .CntW      (CntW),
    .WdogCycles(WdogCycles)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_hart_i    (cmd_hart_i),
    .cmd_op_i      (cmd_op_i),
    .cmd_count_i   (cmd_count_i),
    .issue_i       (issue_i),
    .enable_issue_o(enable_issue_o),
    .issue_cnt_o   (issue_cnt_o),
    .step_done_o   (step_done_o),
    .spurious_o    (spurious_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CntW-1:0] cnt_of(input int h);
    return issue_cnt_o[h*CntW +: CntW];
  endfunction

  // Scoreboard of completed steps.
  typedef struct {
    int              hart;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t sb_head;
  int   done_seen [NrHarts] = '{default: 0};
  int   en_seen   [NrHarts] = '{default: 0};

  always @(negedge clk_i) begin
    for (int h = 0; h < NrHarts; h++) begin
      if (enable_issue_o[h]) en_seen[h]++;
      if (step_done_o[h]) begin
        done_seen[h]++;
        if (sb.size() == 0) begin
          check("unexpected_done_sb_size", sb.size(), 1);
        end else begin
          sb_head = sb.pop_front();
          check("done_hart", h, sb_head.hart);
          check("done_cnt", cnt_of(h), sb_head.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Issue one command, waiting (bounded) for ready. exp_done_cnt >= 0 means
  // this STEP must complete with that issue count.
  task automatic send(input logic [1:0] op, input logic [HartW-1:0] hart,
                      input logic [CntW-1:0] count, input int exp_done_cnt,
                      output int stalls);
    exp_t e;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_hart_i  = hart;
    cmd_count_i = count;
    #1;
    stalls = 0;
    while (!cmd_ready_o && stalls < 100) begin
      tick();
      stalls++;
    end
    if (!cmd_ready_o) check("cmd_accept_timeout_ready", cmd_ready_o, 1);
    @(posedge clk_i);
    if (exp_done_cnt >= 0) begin
      e.hart = int'(hart);
      e.cnt  = CntW'(exp_done_cnt);
      sb.push_back(e);
    end
    tick();
    cmd_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [HartW-1:0] hart;
    logic [CntW-1:0]  count;
    logic             go;         // core willingness on hart 0
    int               run;        // cycles after acceptance
    logic             exp_en;     // enable_issue_o[0] afterwards
    logic [CntW-1:0]  exp_cnt;    // issue count of hart 0 afterwards
    int               exp_dones;  // done pulses on hart 0 during the vector
    int               sb_cnt;     // expected count at done, -1 = none
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog_timer
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int st, n, d0, d1, e0;

    // Hart 0 sequence, starting HALTED with count 3 after the step test.
    vecs[0]  = '{OpClear, 2'd0, 4'd0, 1'b0,  2, 1'b0, 4'd0,  0, -1};
    vecs[1]  = '{OpRun,   2'd0, 4'd0, 1'b1, 17, 1'b1, 4'd1,  0, -1}; // 17 issues wrap to 1
    vecs[2]  = '{OpHalt,  2'd0, 4'd0, 1'b1,  3, 1'b0, 4'd2,  0, -1}; // issue on the HALT edge counts
    vecs[3]  = '{OpStep,  2'd0, 4'd0, 1'b1,  3, 1'b0, 4'd2,  1,  2}; // STEP(0): done, gate stays shut
    vecs[4]  = '{OpStep,  2'd0, 4'd5, 1'b0,  4, 1'b1, 4'd2,  0, -1}; // stepping, core idle
    vecs[5]  = '{OpHalt,  2'd0, 4'd0, 1'b0,  2, 1'b0, 4'd2,  0, -1}; // HALT aborts step, no done
    vecs[6]  = '{OpStep,  2'd0, 4'd2, 1'b1,  4, 1'b0, 4'd4,  1,  4};
    vecs[7]  = '{OpRun,   2'd0, 4'd0, 1'b1,  2, 1'b1, 4'd6,  0, -1};
    vecs[8]  = '{OpStep,  2'd0, 4'd3, 1'b1,  3, 1'b0, 4'd10, 1, 10}; // STEP+issue while RUNNING
    vecs[9]  = '{OpRun,   2'd3, 4'd0, 1'b1,  2, 1'b0, 4'd10, 0, -1}; // out-of-range hart ignored
    vecs[10] = '{OpStep,  2'd3, 4'd1, 1'b0,  1, 1'b0, 4'd10, 0, -1};
    vecs[11] = '{OpClear, 2'd0, 4'd0, 1'b0,  1, 1'b0, 4'd0,  0, -1};

    cmd_valid_i = 1'b0;
    cmd_op_i    = OpHalt;
    cmd_hart_i  = '0;
    cmd_count_i = '0;
    core_go     = '0;
    issue_force = '0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_enable",   enable_issue_o, 0);
    check("rst_cnt",      issue_cnt_o,    0);
    check("rst_done",     step_done_o,    0);
    check("rst_spurious", spurious_o,     0);
    check("rst_timeout",  timeout_o,      0);
    check("rst_ready",    cmd_ready_o,    1);
    rst_i = 1'b0;
    tick();

    // ---- STEP(h0,3) with a core that issues every enabled cycle ----
    core_go = 3'b001;
    e0 = en_seen[0];
    d0 = done_seen[0];
    send(OpStep, 2'd0, 4'd3, 3, st);
    repeat (5) tick();
    check("t2_en_cycles", en_seen[0] - e0, 3);
    check("t2_cnt0",      cnt_of(0), 3);
    check("t2_dones",     done_seen[0] - d0, 1);
    check("t2_cnt1",      cnt_of(1), 0);
    check("t2_enable",    enable_issue_o, 0);
    check("t2_spurious",  spurious_o, 0);
    core_go = '0;

    // ---- back-pressure: STEP(h1,4) then STEP(h1,2) ----
    core_go = 3'b010;
    d1 = done_seen[1];
    send(OpStep, 2'd1, 4'd4, 4, st);
    cmd_valid_i = 1'b1;
    cmd_op_i    = OpStep;
    cmd_hart_i  = 2'd1;
    cmd_count_i = 4'd2;
    #1;
    check("t3_ready_low", cmd_ready_o, 0);
    send(OpStep, 2'd1, 4'd2, 6, st);
    check("t3_stall_cycles", st, 4);
    repeat (4) tick();
    check("t3_cnt1",   cnt_of(1), 6);
    check("t3_dones",  done_seen[1] - d1, 2);
    check("t3_enable", enable_issue_o, 0);
    check("t3_cnt0",   cnt_of(0), 3);
    core_go = '0;

    // ---- spurious issue and CLEAR racing an issue ----
    send(OpClear, 2'd1, 4'd0, -1, st);
    check("t4_clear_cnt", cnt_of(1), 0);
    issue_force = 3'b010;
    tick();
    issue_force = '0;
    check("t4_spurious_set", spurious_o, 3'b010);
    check("t4_spurious_cnt", cnt_of(1), 1);
    issue_force = 3'b010;
    send(OpClear, 2'd1, 4'd0, -1, st);
    issue_force = '0;
    check("t4_clear_spurious", spurious_o, 0);
    check("t4_clear_cnt_race", cnt_of(1), 1);

    // ---- table-driven command sequence on hart 0 ----
    for (int i = 0; i < 12; i++) begin
      core_go = {2'b00, vecs[i].go};
      d0 = done_seen[0];
      e0 = en_seen[0];
      send(vecs[i].op, vecs[i].hart, vecs[i].count, vecs[i].sb_cnt, st);
      repeat (vecs[i].run) tick();
      check($sformatf("vec%0d_stalls", i), st, 0);
      check($sformatf("vec%0d_enable", i), enable_issue_o[0], vecs[i].exp_en);
      check($sformatf("vec%0d_cnt", i),    cnt_of(0), vecs[i].exp_cnt);
      check($sformatf("vec%0d_dones", i),  done_seen[0] - d0, vecs[i].exp_dones);
      if (vecs[i].op == OpStep && vecs[i].count == '0)
        check($sformatf("vec%0d_step0_en_cycles", i), en_seen[0] - e0, 0);
    end
    core_go = '0;

`ifdef ISSUE_WATCHDOG_EN
    // ---- watchdog: STEP(2), one issue, then idle ----
    d1 = done_seen[1];
    send(OpStep, 2'd1, 4'd2, -1, st);
    issue_force = 3'b010;
    tick();
    issue_force = '0;
    check("t6_cnt1", cnt_of(1), 2);
    n = 0;
    while (enable_issue_o[1] && n < 50) begin
      tick();
      n++;
    end
    check("t6_idle_cycles", n, 8);
    check("t6_timeout",  timeout_o, 3'b010);
    check("t6_dones",    done_seen[1] - d1, 0);
    check("t6_spurious", spurious_o, 0);
    send(OpClear, 2'd1, 4'd0, -1, st);
    check("t6_timeout_clear", timeout_o, 0);
`else
    // ---- without the watchdog a stalled step waits indefinitely ----
    d1 = done_seen[1];
    send(OpStep, 2'd1, 4'd2, -1, st);
    repeat (30) tick();
    check("nowd_still_enabled", enable_issue_o[1], 1);
    check("nowd_timeout", timeout_o, 0);
    send(OpHalt, 2'd1, 4'd0, -1, st);
    check("nowd_halted", enable_issue_o[1], 0);
    check("nowd_dones", done_seen[1] - d1, 0);
`endif

    // ---- reset in the middle of STEP(5) after two issues ----
    core_go = 3'b001;
    d0 = done_seen[0];
    send(OpStep, 2'd0, 4'd5, -1, st);
    tick();
    tick();
    check("t1_cnt_before_reset", cnt_of(0), 2);
    rst_i = 1'b1;
    #1;
    check("t1_enable",   enable_issue_o, 0);
    check("t1_cnt",      issue_cnt_o, 0);
    check("t1_done",     step_done_o, 0);
    check("t1_spurious", spurious_o, 0);
    check("t1_timeout",  timeout_o, 0);
    repeat (3) tick();
    core_go = '0;
    rst_i = 1'b0;
    tick();
    check("t1_no_done",       done_seen[0] - d0, 0);
    check("t1_enable_after",  enable_issue_o, 0);
    check("sb_empty",         sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
